// File: rtl/load_align_unit.sv
// Load alignment unit: latches a load request, waits for the memory read handshake and
// returns the extended byte/halfword/word. Define LOAD_TIMEOUT_EN to enable the wait timeout fault.
module load_align_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  OP,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] ldata,
  output logic        misalign,
  output logic        timeout
);

  // Opcode values match instr_def.v (MIPS I-type loads/stores).
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ldata_q, ldata_d;
  logic        mis_q, mis_d;

  // True when the opcode/offset pair cannot be serviced as a load.
  function automatic logic bad_request(input logic [5:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LB, OP_LBU: bad = 1'b0;
      OP_LH, OP_LHU: bad = off[0];
      OP_LW:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LW:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

`ifdef LOAD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`else
  logic [CNT_W-1:0] unused_cfg_s;
  assign unused_cfg_s = CNT_W'(TIMEOUT);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    ldata_d = ldata_q;
    mis_d   = mis_q;
`ifdef LOAD_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = OP;
          off_d = addr_lo;
`ifdef LOAD_TIMEOUT_EN
          cnt_d = {CNT_W{1'b0}};
          to_d  = 1'b0;
`endif
          if (bad_request(OP, addr_lo)) begin
            mis_d   = 1'b1;
            state_d = S_FAULT;
          end else begin
            mis_d   = 1'b0;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          ldata_d = extract(op_q, off_q, mem_rdata);
          state_d = S_DONE;
        end else begin
`ifdef LOAD_TIMEOUT_EN
          // A ready in the last allowed cycle is taken above, so it beats the timeout.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            to_d    = 1'b1;
            state_d = S_FAULT;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_DONE, S_FAULT: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 6'b000000;
      off_q   <= 2'b00;
      ldata_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      cnt_q   <= {CNT_W{1'b0}};
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
`ifdef LOAD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) || (state_q == S_FAULT);
  assign ldata    = ldata_q;
  assign misalign = mis_q;
`ifdef LOAD_TIMEOUT_EN
  assign timeout  = to_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push expected results, a monitor
// pops and compares on every done pulse (value, fault flags and completion cycle).
module tb_load_align_unit;

  localparam int TMO = 4;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [1:0]  addr_lo = 2'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        busy, done, misalign, timeout;
  logic [31:0] ldata;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  logic [31:0] model_ld = 32'h0;

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        mis;
    logic        to;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  load_align_unit #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .OP(op), .addr_lo(addr_lo),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .ldata(ldata), .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_ldata"}, ldata, e.ld);
        chk({e.name, "_misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        chk({e.name, "_timeout"}, {31'd0, timeout}, {31'd0, e.to});
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
  end

  // Issue one request. w = WAIT cycles without mem_ready before it arrives.
  task automatic issue(input string nm, input logic [5:0] o, input logic [1:0] a,
                       input logic [31:0] rd, input int w, input bit hold,
                       input bit e_mis, input bit e_to, input logic [31:0] e_ld);
    exp_t e;
    int k;
    @(negedge clk);
    start = 1'b1; op = o; addr_lo = a; mem_rdata = rd; mem_ready = e_mis;
    @(posedge clk); #1;
    k = cyc;
    if (!hold) start = 1'b0;
    op = ~o; addr_lo = ~a;
    e.name = nm; e.mis = e_mis; e.to = e_to;
    if (e_mis) begin
      e.ld = model_ld; e.cyc = k; sb.push_back(e);
      @(negedge clk);
      mem_ready = 1'b0; start = 1'b0;
    end else if (e_to) begin
      e.ld = model_ld; e.cyc = k + TMO; sb.push_back(e);
      mem_ready = 1'b0;
      repeat (TMO) @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
    end else begin
      model_ld = e_ld;
      e.ld = e_ld; e.cyc = k + 1 + w; sb.push_back(e);
      mem_ready = 1'b0;
      repeat (w) @(posedge clk);
      #1 mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0; start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ldata", ldata, 32'h0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);

    issue("lb0", OP_LB, 2'd0, 32'h80F1_7F02, 0, 0, 0, 0, 32'h0000_0002);
    issue("lb1", OP_LB, 2'd1, 32'h80F1_7F02, 0, 0, 0, 0, 32'h0000_007F);
    issue("lb2", OP_LB, 2'd2, 32'h80F1_7F02, 0, 0, 0, 0, 32'hFFFF_FFF1);
    issue("lb3", OP_LB, 2'd3, 32'h80F1_7F02, 0, 0, 0, 0, 32'hFFFF_FF80);
    issue("lbu3", OP_LBU, 2'd3, 32'h80F1_7F02, 0, 0, 0, 0, 32'h0000_0080);
    issue("lh2", OP_LH, 2'd2, 32'h9ABC_1234, 0, 0, 0, 0, 32'hFFFF_9ABC);
    issue("lhu2", OP_LHU, 2'd2, 32'h9ABC_1234, 0, 0, 0, 0, 32'h0000_9ABC);
    issue("lh0", OP_LH, 2'd0, 32'h9ABC_1234, 0, 0, 0, 0, 32'h0000_1234);
    issue("lw0", OP_LW, 2'd0, 32'h9ABC_1234, 0, 0, 0, 0, 32'h9ABC_1234);

    issue("mis_lw2", OP_LW, 2'd2, 32'h1111_1111, 0, 0, 1, 0, 32'h0);
    issue("mis_lh3", OP_LH, 2'd3, 32'h2222_2222, 0, 0, 1, 0, 32'h0);
    issue("mis_sw", OP_SW, 2'd0, 32'h3333_3333, 0, 0, 1, 0, 32'h0);
    issue("lhu0_after_fault", OP_LHU, 2'd0, 32'h0000_8001, 0, 0, 0, 0, 32'h0000_8001);

    issue("wait5_hold", OP_LBU, 2'd1, 32'h0000_A500, 5, 1, 0, 0, 32'h0000_00A5);

`ifdef LOAD_TIMEOUT_EN
    issue("timeout", OP_LW, 2'd0, 32'h5555_5555, 0, 0, 0, 1, 32'h0);
    issue("ready_last", OP_LW, 2'd0, 32'h1357_9BDF, TMO - 1, 0, 0, 0, 32'h1357_9BDF);
`else
    issue("lw_long", OP_LW, 2'd0, 32'hCAFE_F00D, 40, 0, 0, 0, 32'hCAFE_F00D);
`endif

    // Reset mid-WAIT abandons the read; a late mem_ready must not complete it.
    @(negedge clk);
    start = 1'b1; op = OP_LW; addr_lo = 2'd0; mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_ldata", ldata, 32'h0);
    chk("rst_mid_misalign", {31'd0, misalign}, 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_late_ready_busy", {31'd0, busy}, 32'd0);
    mem_ready = 1'b0;
    model_ld = 32'h0;

    issue("lb_after_reset", OP_LB, 2'd2, 32'h0042_0000, 1, 0, 0, 0, 32'h0000_0042);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
